// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared defines for the multicycle controller
// State codes, ALU ops, opcode/funct values, mux select codes and decode helpers.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_EXEC   = 4'd2,
    ST_MEM_RD = 4'd3,
    ST_MEM_WR = 4'd4,
    ST_WB_ALU = 4'd5,
    ST_WB_MEM = 4'd6,
    ST_BRANCH = 4'd7,
    ST_JUMP   = 4'd8
  } state_e;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_OR  = 2'd2;
  localparam logic [1:0] ALU_LUI = 2'd3;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;

  localparam logic [1:0] SRCB_REG  = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_SEXT = 2'd2;
  localparam logic [1:0] SRCB_ZEXT = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_BRANCH = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  function automatic logic is_exec_op(input logic [5:0] op, input logic [5:0] fn);
    if (op == OP_RTYPE) return (fn == FN_ADD) || (fn == FN_ADDU) || (fn == FN_SUBU);
    return (op == OP_ORI) || (op == OP_LUI) || (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic [1:0] exec_alu_ctl(input logic [5:0] op, input logic [5:0] fn);
    if (op == OP_RTYPE && fn == FN_SUBU) return ALU_SUB;
    if (op == OP_ORI) return ALU_OR;
    if (op == OP_LUI) return ALU_LUI;
    return ALU_ADD;
  endfunction

  function automatic logic [1:0] exec_src_b(input logic [5:0] op);
    if (op == OP_RTYPE) return SRCB_REG;
    if (op == OP_LW || op == OP_SW) return SRCB_SEXT;
    return SRCB_ZEXT;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - counts memory wait cycles and flags when the limit is reached
module mem_wait_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             expired
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == limit);

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multicycle CPU control FSM
// Moore outputs from state; fetch/memory stages abort to FETCH with mem_err on timeout.
module mc_ctrl #(
  parameter int MEM_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  input  logic       mem_ready,
  output logic [1:0] alu_ctl,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       pc_we,
  output logic       ir_we,
  output logic       reg_we,
  output logic       mem_re,
  output logic       mem_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic [1:0] pc_src,
  output logic       illegal,
  output logic       mem_err,
  output logic [3:0] state
);
  import mc_ctrl_pkg::*;

  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  state_e     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic [5:0] fn_q, fn_d;
  logic       is_r;
  logic       in_wait;
  logic       expired;
  logic       timeout;
  logic       timer_en;
  logic       timer_clr;

  assign is_r      = (op_q == OP_RTYPE);
  assign in_wait   = state_q inside {ST_FETCH, ST_MEM_RD, ST_MEM_WR};
  assign timeout   = in_wait & expired;
  assign timer_en  = in_wait & ~mem_ready & ~timeout;
  // A timeout in FETCH returns to FETCH, so it must clear the count explicitly.
  assign timer_clr = (state_d != state_q) | timeout;

  mem_wait_timer #(
    .WIDTH(TW)
  ) u_wait (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clr),
    .enable (timer_en),
    .limit  (TW'(MEM_TIMEOUT)),
    .expired(expired)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    fn_d       = fn_q;
    alu_ctl    = ALU_ADD;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    pc_src     = PCSRC_ALU;
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;
    mem_err    = 1'b0;

    case (state_q)
      ST_FETCH: begin
        alu_src_b = SRCB_FOUR;
        if (timeout) begin
          mem_err = 1'b1;
        end else begin
          mem_re = 1'b1;
          if (mem_ready) begin
            ir_we   = 1'b1;
            pc_we   = 1'b1;
            state_d = ST_DECODE;
          end
        end
      end
      ST_DECODE: begin
        op_d = opcode;
        fn_d = funct;
        if (is_exec_op(opcode, funct)) begin
          state_d = ST_EXEC;
        end else if (opcode == OP_BEQ) begin
          state_d = ST_BRANCH;
        end else if (opcode == OP_J) begin
          state_d = ST_JUMP;
        end else begin
          illegal = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_EXEC: begin
        alu_src_a = 1'b1;
        alu_ctl   = exec_alu_ctl(op_q, fn_q);
        alu_src_b = exec_src_b(op_q);
        if (op_q == OP_LW) begin
          state_d = ST_MEM_RD;
        end else if (op_q == OP_SW) begin
          state_d = ST_MEM_WR;
        end else begin
          state_d = ST_WB_ALU;
        end
      end
      ST_MEM_RD: begin
        if (timeout) begin
          mem_err = 1'b1;
          state_d = ST_FETCH;
        end else begin
          mem_re = 1'b1;
          if (mem_ready) state_d = ST_WB_MEM;
        end
      end
      ST_MEM_WR: begin
        if (timeout) begin
          mem_err = 1'b1;
          state_d = ST_FETCH;
        end else begin
          mem_we = 1'b1;
          if (mem_ready) state_d = ST_FETCH;
        end
      end
      ST_WB_ALU: begin
        // Keep the ALU steering from EXEC so the result stays stable through write-back.
        alu_src_a = 1'b1;
        alu_ctl   = exec_alu_ctl(op_q, fn_q);
        alu_src_b = exec_src_b(op_q);
        reg_we    = ~(is_r && fn_q == FN_ADD && overflow);
        reg_dst   = is_r;
        state_d   = ST_FETCH;
      end
      ST_WB_MEM: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_ctl   = ALU_SUB;
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REG;
        pc_src    = PCSRC_BRANCH;
        pc_we     = zero;
        state_d   = ST_FETCH;
      end
      ST_JUMP: begin
        pc_src  = PCSRC_JUMP;
        pc_we   = 1'b1;
        state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase

    // Reset blocks every write and pulse immediately, even before a clock edge.
    if (rst) begin
      pc_we   = 1'b0;
      ir_we   = 1'b0;
      reg_we  = 1'b0;
      mem_re  = 1'b0;
      mem_we  = 1'b0;
      illegal = 1'b0;
      mem_err = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FETCH;
      op_q    <= '0;
      fn_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      fn_q    <= fn_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - self-checking bench for mc_ctrl
module tb_mc_ctrl;
  import mc_ctrl_pkg::*;

  localparam int TIMEOUT = 8;

  localparam int P_ALU = 14, P_SA = 13, P_SB = 11, P_PCWE = 10, P_IRWE = 9, P_REGWE = 8;
  localparam int P_MRE = 7, P_MWE = 6, P_RDST = 5, P_M2R = 4, P_PCSRC = 2, P_ILL = 1, P_MERR = 0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       overflow = 1'b0;
  logic       mem_ready = 1'b0;
  logic [1:0] alu_ctl;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       pc_we, ir_we, reg_we, mem_re, mem_we;
  logic       reg_dst, mem_to_reg;
  logic [1:0] pc_src;
  logic       illegal, mem_err;
  logic [3:0] state;

  mc_ctrl #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .overflow(overflow), .mem_ready(mem_ready), .alu_ctl(alu_ctl),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_we(pc_we), .ir_we(ir_we),
    .reg_we(reg_we), .mem_re(mem_re), .mem_we(mem_we), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .pc_src(pc_src), .illegal(illegal),
    .mem_err(mem_err), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        mr;
    logic        z;
    logic        ov;
    logic [19:0] exp;
    logic [19:0] mask;
    string       tag;
  } cyc_t;

  cyc_t plan[$];
  cyc_t cur;
  bit   cur_v = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_illegal = 0;
  int   n_mem_err = 0;

  logic [19:0] obs;
  logic [6:0]  enables;
  assign obs = {state, alu_ctl, alu_src_a, alu_src_b, pc_we, ir_we, reg_we, mem_re,
                mem_we, reg_dst, mem_to_reg, pc_src, illegal, mem_err};
  assign enables = {pc_we, ir_we, reg_we, mem_re, mem_we, illegal, mem_err};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Single compare process: every planned cycle is checked against the model.
  always @(negedge clk) begin
    if (!rst && illegal === 1'b1) n_illegal++;
    if (!rst && mem_err === 1'b1) n_mem_err++;
    if (cur_v) begin
      n_chk++;
      if ((obs & cur.mask) !== (cur.exp & cur.mask)) begin
        n_fail++;
        $display("FAIL %s got=%05h want=%05h mask=%05h", cur.tag, obs, cur.exp, cur.mask);
      end
    end
  end

  function automatic cyc_t mk(input logic [3:0] st, input logic [5:0] op, input logic [5:0] fn,
                              input logic mr, input logic z, input logic ov, input string tag);
    cyc_t c;
    c.op = op; c.fn = fn; c.mr = mr; c.z = z; c.ov = ov; c.tag = tag;
    c.exp  = {st, 16'h0000};
    c.mask = 20'hF07C3;
    return c;
  endfunction

  function automatic cyc_t put(input cyc_t ci, input int lsb, input int w, input int v);
    cyc_t c = ci;
    for (int i = 0; i < w; i++) begin
      c.exp[lsb+i]  = v[i];
      c.mask[lsb+i] = 1'b1;
    end
    return c;
  endfunction

  // Waiting stage: `waits` idle cycles then one ready cycle, or a timeout cycle.
  task automatic mem_phase(input string tag, input logic [3:0] st, input int en_pos,
                           input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input logic ov, input int waits, output bit to);
    cyc_t c;
    to = 1'b0;
    for (int i = 0; i <= waits; i++) begin
      if (i == TIMEOUT) begin
        c = mk(st, op, fn, 1'b0, z, ov, {tag, "_timeout"});
        c = put(c, P_MERR, 1, 1);
        plan.push_back(c);
        to = 1'b1;
        return;
      end
      c = mk(st, op, fn, (i == waits), z, ov, tag);
      c = put(c, en_pos, 1, 1);
      if (st == 4'(ST_FETCH)) begin
        c = put(c, P_ALU, 2, int'(ALU_ADD));
        c = put(c, P_SA, 1, 0);
        c = put(c, P_SB, 2, 1);
        if (i == waits) begin
          c = put(c, P_IRWE, 1, 1);
          c = put(c, P_PCWE, 1, 1);
          c = put(c, P_PCSRC, 2, 0);
        end
      end
      plan.push_back(c);
    end
  endtask

  // Instruction-level model; opcode/funct inputs are scrambled after DECODE.
  task automatic instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                       input int wf, input int wm, input logic z, input logic ov);
    cyc_t c;
    bit to;
    bit is_r, ok;
    logic [5:0] opl, fnl;
    int alu, sb;
    opl  = op ^ 6'b110000;
    fnl  = fn ^ 6'b000011;
    is_r = (op == 6'b000000);
    ok   = (is_r && (fn == 6'b100000 || fn == 6'b100001 || fn == 6'b100011)) ||
           op == 6'b001101 || op == 6'b001111 || op == 6'b100011 || op == 6'b101011;
    mem_phase({nm, "_fetch"}, 4'(ST_FETCH), P_MRE, op, fn, z, ov, wf, to);
    if (to) return;
    c = mk(4'(ST_DECODE), op, fn, 1'b1, z, ov, {nm, "_decode"});
    if (!ok && op != 6'b000100 && op != 6'b000010) begin
      c = put(c, P_ILL, 1, 1);
      plan.push_back(c);
      return;
    end
    plan.push_back(c);
    if (op == 6'b000100) begin
      c = mk(4'(ST_BRANCH), opl, fnl, 1'b1, z, ov, {nm, "_branch"});
      c = put(c, P_ALU, 2, int'(ALU_SUB));
      c = put(c, P_SA, 1, 1);
      c = put(c, P_SB, 2, 0);
      c = put(c, P_PCSRC, 2, 1);
      c = put(c, P_PCWE, 1, int'(z));
      plan.push_back(c);
      return;
    end
    if (op == 6'b000010) begin
      c = mk(4'(ST_JUMP), opl, fnl, 1'b1, z, ov, {nm, "_jump"});
      c = put(c, P_PCSRC, 2, 2);
      c = put(c, P_PCWE, 1, 1);
      plan.push_back(c);
      return;
    end
    alu = (is_r && fn == 6'b100011) ? 1 : (op == 6'b001101) ? 2 : (op == 6'b001111) ? 3 : 0;
    sb  = is_r ? 0 : (op == 6'b100011 || op == 6'b101011) ? 2 : 3;
    c = mk(4'(ST_EXEC), opl, fnl, 1'b1, z, ov, {nm, "_exec"});
    c = put(c, P_ALU, 2, alu);
    c = put(c, P_SB, 2, sb);
    plan.push_back(c);
    if (op == 6'b100011) begin
      mem_phase({nm, "_memrd"}, 4'(ST_MEM_RD), P_MRE, opl, fnl, z, ov, wm, to);
      if (to) return;
      c = mk(4'(ST_WB_MEM), opl, fnl, 1'b1, z, ov, {nm, "_wbmem"});
      c = put(c, P_REGWE, 1, 1);
      c = put(c, P_M2R, 1, 1);
      c = put(c, P_RDST, 1, 0);
      plan.push_back(c);
    end else if (op == 6'b101011) begin
      mem_phase({nm, "_memwr"}, 4'(ST_MEM_WR), P_MWE, opl, fnl, z, ov, wm, to);
    end else begin
      c = mk(4'(ST_WB_ALU), opl, fnl, 1'b1, z, ov, {nm, "_wbalu"});
      c = put(c, P_ALU, 2, alu);
      c = put(c, P_REGWE, 1, int'(!(is_r && fn == 6'b100000 && ov)));
      c = put(c, P_M2R, 1, 0);
      c = put(c, P_RDST, 1, int'(is_r));
      plan.push_back(c);
    end
  endtask

  task automatic instr_len(input string nm, input logic [5:0] op, input logic [5:0] fn,
                           input int wf, input int wm, input logic z, input logic ov,
                           input int want);
    int n0 = plan.size();
    instr(nm, op, fn, wf, wm, z, ov);
    check({nm, "_cycles"}, 32'(plan.size() - n0), 32'(want));
  endtask

  task automatic play();
    while (plan.size() > 0) begin
      @(posedge clk);
      #1;
      rst       = 1'b0;
      cur       = plan.pop_front();
      opcode    = cur.op;
      funct     = cur.fn;
      mem_ready = cur.mr;
      zero      = cur.z;
      overflow  = cur.ov;
      cur_v     = 1'b1;
    end
    @(negedge clk);
    #1;
    cur_v = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    check("rst_state", 32'(state), 32'(ST_FETCH));
    check("rst_enables", 32'(enables), 0);
    @(posedge clk);
    #1;
    check("rst_edge_state", 32'(state), 32'(ST_FETCH));
    check("rst_edge_enables", 32'(enables), 0);

    instr_len("addu",      6'b000000, 6'b100001, 0, 0, 1'b0, 1'b0, 4);
    instr_len("add_ovf",   6'b000000, 6'b100000, 0, 0, 1'b0, 1'b1, 4);
    instr_len("add",       6'b000000, 6'b100000, 0, 0, 1'b0, 1'b0, 4);
    instr_len("addu_ovf",  6'b000000, 6'b100001, 0, 0, 1'b0, 1'b1, 4);
    instr_len("subu",      6'b000000, 6'b100011, 0, 0, 1'b0, 1'b0, 4);
    instr_len("ori",       6'b001101, 6'b010101, 0, 0, 1'b0, 1'b0, 4);
    instr_len("lui",       6'b001111, 6'b000000, 0, 0, 1'b0, 1'b0, 4);
    instr_len("lw",        6'b100011, 6'b000000, 0, 0, 1'b0, 1'b0, 5);
    instr_len("lw_wait3",  6'b100011, 6'b000000, 0, 3, 1'b0, 1'b0, 8);
    instr_len("sw",        6'b101011, 6'b000000, 0, 0, 1'b0, 1'b0, 4);
    instr_len("sw_wait",   6'b101011, 6'b000000, 2, 2, 1'b0, 1'b0, 8);
    instr_len("beq_taken", 6'b000100, 6'b000000, 0, 0, 1'b1, 1'b0, 3);
    instr_len("beq_not",   6'b000100, 6'b000000, 0, 0, 1'b0, 1'b0, 3);
    instr_len("j",         6'b000010, 6'b000000, 0, 0, 1'b0, 1'b0, 3);
    instr_len("illegal",   6'b111111, 6'b000000, 0, 0, 1'b0, 1'b0, 2);
    instr_len("bad_funct", 6'b000000, 6'b000000, 0, 0, 1'b0, 1'b0, 2);
    instr_len("fetch_to",  6'b000000, 6'b100001, 8, 0, 1'b0, 1'b0, 9);
    instr_len("lw_to",     6'b100011, 6'b000000, 0, 8, 1'b0, 1'b0, 12);
    instr_len("fetch_w7",  6'b000000, 6'b100001, 7, 0, 1'b0, 1'b0, 11);
    play();

    // Abort a store mid-access with an asynchronous reset.
    instr("sw_abort", 6'b101011, 6'b000000, 0, 3, 1'b0, 1'b0);
    while (plan.size() > 4) plan.delete(plan.size() - 1);
    play();
    check("pre_abort_state", 32'(state), 32'(ST_MEM_WR));
    check("pre_abort_mem_we", 32'(mem_we), 1);
    #1;
    rst = 1'b1;
    #1;
    check("arst_state", 32'(state), 32'(ST_FETCH));
    check("arst_enables", 32'(enables), 0);
    @(posedge clk);
    #1;
    check("arst_edge_state", 32'(state), 32'(ST_FETCH));
    check("arst_edge_enables", 32'(enables), 0);

    instr_len("j_after_rst", 6'b000010, 6'b000000, 0, 0, 1'b0, 1'b0, 3);
    instr_len("addu_final",  6'b000000, 6'b100001, 0, 0, 1'b0, 1'b0, 4);
    play();

    check("illegal_pulses", 32'(n_illegal), 2);
    check("mem_err_pulses", 32'(n_mem_err), 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Parameter: MEM_TIMEOUT, 8, max wait cycles for mem_ready before mem_err pulse and return to FETCH.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 opcode  input  6  instruction bits [31:26], valid from IR after FETCH.
REQ-005 funct  input  6  instruction bits [5:0].
REQ-006 zero  input  1  ALU zero flag.
REQ-007 overflow  input  1  ALU signed-add overflow flag.
REQ-008 mem_ready  input  1  memory handshake, access completes in any cycle it is high.
REQ-009 alu_ctl  output  2  ALU operation, encodings ADD/SUB/OR/LUI from the shared defines.
REQ-010 alu_src_a  output  1  0 = PC, 1 = register A.
REQ-011 alu_src_b  output  2  0 = register B, 1 = constant 4, 2 = sign-ext imm, 3 = zero-ext imm.
REQ-012 pc_we, ir_we, reg_we, mem_re, mem_we  output  1 each  write/read enables.
REQ-013 reg_dst  output  1  0 = rt, 1 = rd; mem_to_reg output 1; pc_src output 2 (0 = ALU, 1 = branch target, 2 = jump target).
REQ-014 illegal, mem_err  output  1 each  single-cycle error pulses; state  output  4  current state code for debug.

Function
REQ-015 FSM states SHALL be FETCH, DECODE, EXEC, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JUMP; all outputs combinational from state (Moore) except pc_we/ir_we/mem_err gated by mem_ready/timeout.
REQ-016 FETCH: mem_re=1, alu_src_a=0, alu_src_b=1, alu_ctl=ADD; when mem_ready=1 assert ir_we and pc_we with pc_src=0, go DECODE; else stay.
REQ-017 DECODE: always one cycle; opcode 000000 with funct 100000/100001/100011, or 001101/001111/100011/101011 -> EXEC; 000100 -> BRANCH; 000010 -> JUMP; any other -> pulse illegal, go FETCH.
REQ-018 EXEC: alu_ctl ADD for add/addu/lw/sw, SUB for subu, OR for ori, LUI for lui; alu_src_b 0 for R-type, 2 for lw/sw, 3 for ori/lui; next WB_ALU, or MEM_RD for lw, MEM_WR for sw.
REQ-019 MEM_RD: mem_re=1 until mem_ready, then WB_MEM; MEM_WR: mem_we=1 until mem_ready, then FETCH.
REQ-020 WB_ALU: reg_we=1, mem_to_reg=0, reg_dst=1 for R-type else 0; reg_we SHALL be 0 for funct 100000 (add) when overflow=1; next FETCH.
REQ-021 WB_MEM: reg_we=1, mem_to_reg=1, reg_dst=0; next FETCH.
REQ-022 BRANCH: alu_ctl=SUB, alu_src_a=1, alu_src_b=0, pc_src=1, pc_we=zero; next FETCH. JUMP: pc_src=2, pc_we=1; next FETCH.
REQ-023 Wait counter SHALL count cycles in FETCH/MEM_RD/MEM_WR with mem_ready=0, clear on state change; on reaching MEM_TIMEOUT pulse mem_err, no enables, go FETCH.
REQ-024 Opcode/funct SHALL be latched in DECODE; changes on inputs after DECODE SHALL not affect the instruction in flight.
REQ-025 Cycle counts with mem_ready tied high: R-type/ori/lui 4, lw 5, sw 4, beq 3, j 3.

Reset
REQ-026 rst=1 SHALL immediately force state=FETCH, wait counter 0, latched opcode/funct 0, all enables and error pulses 0, independent of clk.
REQ-027 Reset asserted mid-instruction SHALL abort it with no register, memory or PC write on the following edge.
REQ-028 First fetch SHALL begin on the first rising clk after rst deasserts.

Structure
REQ-029 State encodings, opcode/funct constants and alu_src_b/pc_src codes SHALL live in the shared defines header alongside the ALU op codes.
REQ-030 Wait counter SHALL be a sub-module mem_wait_timer (clear, enable, limit, expired); rest is one FSM module.

Verification
REQ-031 addu (op 0, funct 100001), mem_ready=1 -> states FETCH,DECODE,EXEC,WB_ALU; reg_we=1, reg_dst=1, alu_ctl=ADD in cycle 3-4.
REQ-032 add with overflow=1 in WB_ALU -> reg_we=0, returns FETCH next cycle.
REQ-033 lw with mem_ready low 3 cycles in MEM_RD -> stays MEM_RD 3 cycles, then WB_MEM with mem_to_reg=1; total 8 cycles.
REQ-034 beq zero=1 -> pc_we=1 pc_src=1 in BRANCH; zero=0 -> pc_we=0; opcode 111111 -> illegal pulse in DECODE, back to FETCH.
REQ-035 mem_ready held 0 in FETCH -> mem_err pulses after 8 waiting cycles, no ir_we; rst pulsed during MEM_WR -> state=FETCH asynchronously, mem_we=0.
